// File: rtl/color_wheel_pkg.sv
// Shared types and derived-parameter helpers for the color_wheel_pwm engine.
package color_wheel_pkg;

  typedef enum logic [1:0] {
    WHEEL   = 2'd0,
    BREATHE = 2'd1,
    HOLD    = 2'd2
  } mode_e;

  function automatic int calc_step_div(input int clk_fre, input int step_hz);
    return clk_fre / step_hz;
  endfunction

  function automatic int calc_pwm_div(input int clk_fre, input int pwm_fre, input int duty_max);
    int d;
    d = clk_fre / (pwm_fre * duty_max);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int calc_phase_w(input int ch);
    return $clog2(2 * ch);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Even leg 2k raises channel (k+1)%ch; odd leg 2k+1 lowers channel k.
  function automatic int leg_channel(input int leg, input int ch);
    return ((leg % 2) == 0) ? (((leg / 2) + 1) % ch) : (leg / 2);
  endfunction

  function automatic logic leg_is_up(input int leg);
    return (leg % 2) == 0;
  endfunction

endpackage

// File: rtl/pwm_ch_out.sv
// One PWM channel: period-aligned duty latch, optional brightness scaling
// (BRIGHT_EN macro) and registered compare output.
module pwm_ch_out
  import color_wheel_pkg::*;
#(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DUTY_W-1:0] cnt_i,
  input  logic [DUTY_W-1:0] duty_i,
`ifdef BRIGHT_EN
  input  logic [DUTY_W-1:0] bright_i,
`endif
  output logic              pwm_o
);

  logic [DUTY_W-1:0] eff_duty;
  logic [DUTY_W-1:0] duty_lat_q;
  logic              pwm_q;

`ifdef BRIGHT_EN
  localparam int PW = 2 * DUTY_W + 1;
  logic [PW-1:0] prod;
  logic [PW-1:0] prod_sh;

  assign prod    = PW'(duty_i) * PW'({1'b0, bright_i} + (DUTY_W + 1)'(1));
  assign prod_sh = prod >> DUTY_W;
  // The scaled value can never exceed duty_i; the clamp is only a guard.
  assign eff_duty = (prod_sh > PW'({DUTY_W{1'b1}})) ? {DUTY_W{1'b1}} : prod_sh[DUTY_W-1:0];
`else
  assign eff_duty = duty_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_lat_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      if (load_i) duty_lat_q <= eff_duty;
      pwm_q <= (cnt_i < duty_lat_q);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/color_wheel_pwm.sv
// Colour-wheel / breathe / hold duty sequencer with per-channel PWM outputs.
// Optional BRIGHT_EN macro adds a global brightness input that scales pwm_out only.
module color_wheel_pwm
  import color_wheel_pkg::*;
#(
  parameter int CLK_FRE = 27_000_000,
  parameter int CH      = 3,
  parameter int DUTY_W  = 8,
  parameter int STEP_HZ = 100,
  parameter int PWM_FRE = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [1:0]                  mode,
  input  logic [CH-1:0]               ch_mask,
`ifdef BRIGHT_EN
  input  logic [DUTY_W-1:0]           bright,
`endif
  output logic [CH-1:0][DUTY_W-1:0]   duty,
  output logic [CH-1:0]               pwm_out,
  output logic [$clog2(2*CH)-1:0]     phase,
  output logic                        wrap
);

  localparam int DUTY_MAX = 2 ** DUTY_W - 1;
  localparam int STEP_DIV = calc_step_div(CLK_FRE, STEP_HZ);
  localparam int PWM_DIV  = calc_pwm_div(CLK_FRE, PWM_FRE, DUTY_MAX);
  localparam int PH_W     = calc_phase_w(CH);
  localparam int STEP_W   = cnt_w(STEP_DIV);
  localparam int PRE_W    = cnt_w(PWM_DIV);
  localparam int CI_W     = cnt_w(CH);
  localparam logic [DUTY_W-1:0]    DMAX      = {DUTY_W{1'b1}};
  localparam logic [PH_W-1:0]      LAST_LEG  = PH_W'(2 * CH - 1);
  localparam logic [CH*DUTY_W-1:0] DUTY_INIT = {{((CH - 1) * DUTY_W){1'b0}}, DMAX};

  // Tick divider runs regardless of en.
  logic [STEP_W-1:0] step_cnt_q;
  logic              tick;

  assign tick = (step_cnt_q == STEP_W'(STEP_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       step_cnt_q <= '0;
    else if (tick) step_cnt_q <= '0;
    else           step_cnt_q <= step_cnt_q + STEP_W'(1);
  end

  mode_e                     mode_in, mode_q, mode_d;
  logic [CH-1:0][DUTY_W-1:0] duty_q, duty_d;
  logic [PH_W-1:0]           phase_q, phase_d;
  logic [DUTY_W-1:0]         level_q, level_d;
  logic                      dir_up_q, dir_up_d;
  logic                      wrap_q, wrap_d;
  logic [CI_W-1:0]           tgt;
  logic                      tgt_up;
  logic [DUTY_W-1:0]         tgt_duty;
  logic                      tgt_sat;

  always_comb begin
    case (mode)
      2'd0:    mode_in = WHEEL;
      2'd1:    mode_in = BREATHE;
      default: mode_in = HOLD;
    endcase
  end

  assign tgt      = CI_W'(leg_channel(int'(phase_q), CH));
  assign tgt_up   = leg_is_up(int'(phase_q));
  assign tgt_duty = duty_q[tgt];
  assign tgt_sat  = tgt_up ? (tgt_duty == DMAX) : (tgt_duty == '0);

  always_comb begin
    mode_d   = mode_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    level_d  = level_q;
    dir_up_d = dir_up_q;
    wrap_d   = 1'b0;
    if (tick && en) begin
      if (mode_in != mode_q) begin
        // A mode switch spends its tick on re-initialisation only.
        mode_d = mode_in;
        if (mode_in == WHEEL) begin
          phase_d = '0;
          duty_d  = DUTY_INIT;
        end else if (mode_in == BREATHE) begin
          level_d  = '0;
          dir_up_d = 1'b1;
          duty_d   = '0;
        end
      end else begin
        case (mode_q)
          WHEEL: begin
            if (tgt_sat) begin
              if (phase_q == LAST_LEG) begin
                phase_d = '0;
                wrap_d  = 1'b1;
              end else begin
                phase_d = phase_q + PH_W'(1);
              end
            end else begin
              duty_d[tgt] = tgt_up ? tgt_duty + DUTY_W'(1) : tgt_duty - DUTY_W'(1);
            end
          end
          BREATHE: begin
            if (dir_up_q) begin
              if (level_q == DMAX) dir_up_d = 1'b0;
              else                 level_d  = level_q + DUTY_W'(1);
            end else begin
              if (level_q == '0) begin
                dir_up_d = 1'b1;
                wrap_d   = 1'b1;
              end else begin
                level_d = level_q - DUTY_W'(1);
              end
            end
            for (int i = 0; i < CH; i++) duty_d[i] = ch_mask[i] ? level_d : '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= WHEEL;
      duty_q   <= DUTY_INIT;
      phase_q  <= '0;
      level_q  <= '0;
      dir_up_q <= 1'b1;
      wrap_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      level_q  <= level_d;
      dir_up_q <= dir_up_d;
      wrap_q   <= wrap_d;
    end
  end

  assign duty  = duty_q;
  assign phase = phase_q;
  assign wrap  = wrap_q;

  // Shared PWM timebase; period_end marks the last count so latches reload as pwm_cnt returns to 0.
  logic [PRE_W-1:0]  pre_cnt_q;
  logic [DUTY_W-1:0] pwm_cnt_q;
  logic              pwm_step;
  logic              period_end;

  assign pwm_step   = (pre_cnt_q == PRE_W'(PWM_DIV - 1));
  assign period_end = pwm_step && (pwm_cnt_q == DUTY_W'(DUTY_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pwm_step ? '0 : pre_cnt_q + PRE_W'(1);
      if (pwm_step) pwm_cnt_q <= period_end ? '0 : pwm_cnt_q + DUTY_W'(1);
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    pwm_ch_out #(
      .DUTY_W(DUTY_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load_i  (period_end),
      .cnt_i   (pwm_cnt_q),
      .duty_i  (duty_q[gi]),
`ifdef BRIGHT_EN
      .bright_i(bright),
`endif
      .pwm_o   (pwm_out[gi])
    );
  end

endmodule

// File: tb/tb_color_wheel_pwm.sv
// Directed bench for color_wheel_pwm: CH=3 and CH=4 instances, DUTY_W=3, STEP_DIV=10, PWM_DIV=1.
module tb_color_wheel_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] mask3;
  logic [3:0] mask4;
`ifdef BRIGHT_EN
  logic [2:0] bright;
  localparam int EXP_C0 = 3;
  localparam int EXP_C1 = 1;
`else
  localparam int EXP_C0 = 7;
  localparam int EXP_C1 = 3;
`endif

  logic [2:0][2:0] duty3;
  logic [2:0]      pwm3;
  logic [2:0]      phase3;
  logic            wrap3;
  logic [3:0][2:0] duty4;
  logic [3:0]      pwm4;
  logic [2:0]      phase4;
  logic            wrap4;

  always #5 clk = ~clk;

  color_wheel_pwm #(.CLK_FRE(1000), .CH(3), .DUTY_W(3), .STEP_HZ(100), .PWM_FRE(100)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ch_mask(mask3),
`ifdef BRIGHT_EN
    .bright(bright),
`endif
    .duty(duty3), .pwm_out(pwm3), .phase(phase3), .wrap(wrap3)
  );

  color_wheel_pwm #(.CLK_FRE(1000), .CH(4), .DUTY_W(3), .STEP_HZ(100), .PWM_FRE(100)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ch_mask(mask4),
`ifdef BRIGHT_EN
    .bright(bright),
`endif
    .duty(duty4), .pwm_out(pwm4), .phase(phase4), .wrap(wrap4)
  );

  // Cycle count since reset release: at the negedge after posedge n, cyc == n.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int       w3_cnt = 0;
  int       w4_cnt = 0;
  bit [7:0] ph4_seen = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (wrap3) w3_cnt <= w3_cnt + 1;
      if (wrap4) w4_cnt <= w4_cnt + 1;
      ph4_seen[phase4] <= 1'b1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_cyc", 32'(cyc), 32'(n));
  endtask

  task automatic measure(input int first, output int c0, output int c1, output int c2);
    wait_cyc(first);
    c0 = 0; c1 = 0; c2 = 0;
    repeat (7) begin
      c0 += int'(pwm3[0]);
      c1 += int'(pwm3[1]);
      c2 += int'(pwm3[2]);
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          ticks;
    logic [8:0]  d3;
    logic [2:0]  p3;
    logic        w3;
    logic [11:0] d4;
    logic [2:0]  p4;
    logic        w4;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int c0, c1, c2;
    logic [2:0] lvl;
    logic       up;
    logic       wexp;

    tbl[0]  = '{0,  9'o007, 3'd0, 1'b0, 12'o0007, 3'd0, 1'b0};
    tbl[1]  = '{1,  9'o017, 3'd0, 1'b0, 12'o0017, 3'd0, 1'b0};
    tbl[2]  = '{3,  9'o037, 3'd0, 1'b0, 12'o0037, 3'd0, 1'b0};
    tbl[3]  = '{7,  9'o077, 3'd0, 1'b0, 12'o0077, 3'd0, 1'b0};
    tbl[4]  = '{8,  9'o077, 3'd1, 1'b0, 12'o0077, 3'd1, 1'b0};
    tbl[5]  = '{9,  9'o076, 3'd1, 1'b0, 12'o0076, 3'd1, 1'b0};
    tbl[6]  = '{16, 9'o070, 3'd2, 1'b0, 12'o0070, 3'd2, 1'b0};
    tbl[7]  = '{20, 9'o470, 3'd2, 1'b0, 12'o0470, 3'd2, 1'b0};
    tbl[8]  = '{24, 9'o770, 3'd3, 1'b0, 12'o0770, 3'd3, 1'b0};
    tbl[9]  = '{32, 9'o700, 3'd4, 1'b0, 12'o0700, 3'd4, 1'b0};
    tbl[10] = '{40, 9'o707, 3'd5, 1'b0, 12'o7700, 3'd5, 1'b0};
    tbl[11] = '{47, 9'o007, 3'd5, 1'b0, 12'o7000, 3'd5, 1'b0};
    tbl[12] = '{48, 9'o007, 3'd0, 1'b1, 12'o7000, 3'd6, 1'b0};
    tbl[13] = '{56, 9'o077, 3'd1, 1'b0, 12'o7007, 3'd7, 1'b0};
    tbl[14] = '{63, 9'o070, 3'd1, 1'b0, 12'o0007, 3'd7, 1'b0};
    tbl[15] = '{64, 9'o070, 3'd2, 1'b0, 12'o0007, 3'd0, 1'b1};

    rst = 1'b1; en = 1'b1; mode = 2'd0; mask3 = 3'b101; mask4 = 4'b0101;
`ifdef BRIGHT_EN
    bright = 3'd3;
`endif
    repeat (3) @(negedge clk);
    chk("rst_pwm3", 32'(pwm3), 32'h0);
    chk("rst_wrap3", 32'(wrap3), 32'h0);
    chk("rst_pwm4", 32'(pwm4), 32'h0);
    rst = 1'b0;

    // Wheel sequence on both channel counts.
    for (int i = 0; i < 16; i++) begin
      wait_cyc(tbl[i].ticks * 10);
      $display("vec %0d ticks=%0d duty3=%0o phase3=%0d duty4=%0o phase4=%0d",
               i, tbl[i].ticks, duty3, phase3, duty4, phase4);
      chk("wheel_duty3", 32'(duty3), 32'(tbl[i].d3));
      chk("wheel_phase3", 32'(phase3), 32'(tbl[i].p3));
      chk("wheel_wrap3", 32'(wrap3), 32'(tbl[i].w3));
      chk("wheel_duty4", 32'(duty4), 32'(tbl[i].d4));
      chk("wheel_phase4", 32'(phase4), 32'(tbl[i].p4));
      chk("wheel_wrap4", 32'(wrap4), 32'(tbl[i].w4));
    end
    #1;
    chk("wrap3_count", 32'(w3_cnt), 32'd1);
    chk("wrap4_count", 32'(w4_cnt), 32'd1);
    chk("phase4_visits", 32'(ph4_seen), 32'hff);

    // Asynchronous reset mid-leg, checked before the next clock edge.
    #1 rst = 1'b1;
    #1;
    $display("async reset: duty3=%0o phase3=%0d duty4=%0o", duty3, phase3, duty4);
    chk("async_duty3", 32'(duty3), 32'(9'o007));
    chk("async_phase3", 32'(phase3), 32'd0);
    chk("async_wrap3", 32'(wrap3), 32'd0);
    chk("async_pwm3", 32'(pwm3), 32'd0);
    chk("async_duty4", 32'(duty4), 32'(12'o0007));
    @(negedge clk) rst = 1'b0;

    // Enable freeze and resume without catch-up.
    wait_cyc(30);
    chk("en_before", 32'(duty3), 32'(9'o037));
    en = 1'b0;
    wait_cyc(80);
    chk("en_frozen", 32'(duty3), 32'(9'o037));
    en = 1'b1;
    wait_cyc(89);
    chk("en_pretick", 32'(duty3), 32'(9'o037));
    wait_cyc(90);
    $display("en resume: duty3=%0o", duty3);
    chk("en_resume", 32'(duty3), 32'(9'o047));

    // PWM duty ratios in HOLD, then a mid-period duty change.
    #2 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    wait_cyc(30);
    mode = 2'd2;
    measure(36, c0, c1, c2);
    $display("pwm period: ch0=%0d ch1=%0d ch2=%0d", c0, c1, c2);
    chk("pwm_hold_c0", 32'(c0), 32'(EXP_C0));
    chk("pwm_hold_c1", 32'(c1), 32'(EXP_C1));
    chk("pwm_hold_c2", 32'(c2), 32'd0);
    wait_cyc(50);
    chk("hold_duty", 32'(duty3), 32'(9'o037));
    wait_cyc(52);
    mode = 2'd0;
    measure(57, c0, c1, c2);
    $display("pwm period with mid-period change: ch0=%0d ch1=%0d ch2=%0d", c0, c1, c2);
    chk("pwm_mid_c1", 32'(c1), 32'(EXP_C1));
    chk("pwm_mid_c0", 32'(c0), 32'(EXP_C0));
    chk("wheel_reentry", 32'(duty3), 32'(9'o007));
    measure(64, c0, c1, c2);
    $display("pwm next period: ch0=%0d ch1=%0d ch2=%0d", c0, c1, c2);
    chk("pwm_next_c1", 32'(c1), 32'd0);
    chk("pwm_next_c0", 32'(c0), 32'(EXP_C0));
    chk("pwm_next_c2", 32'(c2), 32'd0);

    // Breathe with mask 101: entry tick, then 16 ticks 0->7->0.
    wait_cyc(72);
    mode = 2'd1;
    wait_cyc(80);
    chk("breathe_entry", 32'(duty3), 32'd0);
    chk("breathe_entry_wrap", 32'(wrap3), 32'd0);
    lvl = 3'd0;
    up  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      wexp = 1'b0;
      if (up) begin
        if (lvl == 3'd7) up = 1'b0;
        else             lvl = lvl + 3'd1;
      end else begin
        if (lvl == 3'd0) begin
          up   = 1'b1;
          wexp = 1'b1;
        end else begin
          lvl = lvl - 3'd1;
        end
      end
      wait_cyc(80 + 10 * k);
      $display("breathe tick %0d: duty3=%0o wrap3=%0d", k, duty3, wrap3);
      chk("breathe_duty", 32'(duty3), 32'({lvl, 3'd0, lvl}));
      chk("breathe_wrap", 32'(wrap3), 32'(wexp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
